// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Request fields held for the duration of one transaction.
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Misaligned halfword/word or reserved size code.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the memory stage and the load/store unit.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extract/extend and store lane merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_data_c_o,
  output logic [DATA_W-1:0] st_word_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Pick the addressed lane(s) of the fetched word.
  always_comb begin
    byte_c = word_i[{addr_lo_i, 3'b000} +: 8];
    half_c = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Load data: extend the selected byte/half; words pass through.
  always_comb begin
    ld_data_c_o = word_i;
    case (size_i)
      SZ_BYTE: ld_data_c_o = uns_i ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: ld_data_c_o = uns_i ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
      default: ld_data_c_o = word_i;
    endcase
  end

  // Store data: replace only the addressed lane(s) of the fetched word.
  always_comb begin
    st_word_c_o = word_i;
    case (size_i)
      SZ_BYTE: st_word_c_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (addr_lo_i[1]) st_word_c_o[31:16] = wdata_i[15:0];
        else              st_word_c_o[15:0]  = wdata_i[15:0];
      end
      SZ_WORD: st_word_c_o = wdata_i;
      default: st_word_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for a 256x32 word-addressed bank; sub-word stores via read-modify-write.
// Optional build macro LSU_STATS_EN adds load/store/error response counters.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
);

  state_e            state_q, state_d;
  req_t              req_q;
  logic              accept_c, acc_err_c;
  logic [DATA_W-1:0] ld_data_c, st_word_c;
  logic [ADDR_W-1:0] addr_base_c;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  assign accept_c  = bus.req_valid && req_ready_q;
  assign acc_err_c = access_err(bus.req_size, bus.req_addr[1:0]);

  lsu_lane_align u_align (
    .word_i      (mem_rdata),
    .addr_lo_i   (req_q.addr[1:0]),
    .size_i      (req_q.size),
    .uns_i       (req_q.uns),
    .wdata_i     (req_q.wdata),
    .ld_data_c_o (ld_data_c),
    .st_word_c_o (st_word_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Capture the request on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (accept_c) begin
      req_q.we    <= bus.req_we;
      req_q.size  <= bus.req_size;
      req_q.uns   <= bus.req_unsigned;
      req_q.addr  <= bus.req_addr;
      req_q.wdata <= bus.req_wdata;
    end
  end

  // Next state: errors skip memory, word stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (acc_err_c)                  state_d = ST_RESP;
          else if (!bus.req_we)           state_d = ST_RD;
          else if (bus.req_size == SZ_WORD) state_d = ST_WR;
          else                            state_d = ST_RD;
        end
      end
      ST_RD:   state_d = req_q.we ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so outputs register with the state.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    mem_read_d  = (state_d == ST_RD);
    mem_write_d = (state_d == ST_WR);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = (state_d == ST_RESP) && (state_q == ST_IDLE);
    rsp_rdata_d = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    addr_base_c = (state_q == ST_IDLE) ? bus.req_addr : req_q.addr;
    if (mem_read_d || mem_write_d) begin
      mem_addr_d = {addr_base_c[ADDR_W-1:2], 2'b00};
    end
    if (mem_write_d) begin
      mem_wdata_d = (state_q == ST_IDLE) ? bus.req_wdata : st_word_c;
    end
    if ((state_q == ST_RD) && (state_d == ST_RESP)) begin
      rsp_rdata_d = ld_data_c;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

`ifdef LSU_STATS_EN
  logic [31:0] stat_loads_q, stat_stores_q, stat_errs_q;

  // Count each response by type while it is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else if (state_q == ST_RESP) begin
      if (rsp_err_q)     stat_errs_q   <= stat_errs_q + 32'd1;
      else if (req_q.we) stat_stores_q <= stat_stores_q + 32'd1;
      else               stat_loads_q  <= stat_loads_q + 32'd1;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`else
  assign stat_loads  = 32'd0;
  assign stat_stores = 32'd0;
  assign stat_errs   = 32'd0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stat_loads, stat_stores, stat_errs;

  // Bank model: combinational read, write at the clock edge; preload port for setup.
  logic [31:0] bank [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;
  assign mem_rdata = bank[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pre_we)         bank[pre_idx] <= pre_val;
    else if (mem_write) bank[mem_addr[9:2]] <= mem_wdata;
  end

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    time         t_acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ref_bytes [1024];
  int          checks = 0;
  int          errors = 0;
  int          n_rd = 0, n_wr = 0;
  int          m_loads = 0, m_stores = 0, m_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: byte-granular memory, little-endian assembly, arithmetic extension.
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          n, a;
    logic [31:0] v;
    e.rdata = 32'd0;
    e.t_acc = 0;
    e.err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
    if (e.err) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
      m_errs++;
      return e;
    end
    n = 1 << sz;
    a = int'(addr[9:0]);
    if (!we) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      e.rdata = v; e.lat = 2; e.nrd = 1; e.nwr = 0;
      m_loads++;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[a + i] = wd[8 * i +: 8];
      e.nwr = 1;
      e.nrd = (n < 4) ? 1 : 0;
      e.lat = (n < 4) ? 3 : 2;
      m_stores++;
    end
    return e;
  endfunction

  // Issue one request from a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit has_k, input logic [31:0] k);
    exp_t e;
    int   w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    e = model(we, sz, uns, addr, wd);
    if (has_k) e.rdata = k;
    @(posedge clk);
    e.t_acc = $time;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = 8'(idx); pre_val = val;
    for (int i = 0; i < 4; i++) ref_bytes[4 * idx + i] = val[8 * i +: 8];
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Monitor: bus invariants every cycle and response check against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (rst) begin
      n_rd = 0;
      n_wr = 0;
    end else begin
      if (mem_read)  n_rd++;
      if (mem_write) n_wr++;
      if (mem_read || mem_write) begin
        check("rd_wr_exclusive", 32'(mem_read && mem_write), 32'd0);
        check("mem_addr_lo", 32'(mem_addr[1:0]), 32'd0);
        check("mem_during_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      if (!mem_write) check("mem_wdata_idle", mem_wdata, 32'd0);
      if (bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          lat = int'(($time - e.t_acc - 5) / 10) + 1;
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("latency", 32'(lat), 32'(e.lat));
          check("mem_read_pulses", 32'(n_rd), 32'(e.nrd));
          check("mem_write_pulses", 32'(n_wr), 32'(e.nwr));
        end
        n_rd = 0;
        n_wr = 0;
      end
    end
  end

  initial begin : driver
    int w;
    logic [31:0] a;
    logic [1:0]  sz;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    pre_we = 1'b0; pre_idx = 8'd0; pre_val = 32'd0;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_stat_loads", stat_loads, 32'd0);

    // Directed cases around word 0x10.
    set_word(4, 32'h8899AABB);
    issue(0, 2'd0, 0, 32'h11, 32'h0, 1, 32'hFFFFFFAA);
    issue(0, 2'd0, 1, 32'h11, 32'h0, 1, 32'h000000AA);
    issue(0, 2'd1, 0, 32'h12, 32'h0, 1, 32'hFFFF8899);
    issue(0, 2'd1, 1, 32'h12, 32'h0, 1, 32'h00008899);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 32'h8899AABB);
    issue(1, 2'd1, 0, 32'h12, 32'h00001234, 1, 32'h0);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 32'h1234AABB);
    issue(1, 2'd0, 0, 32'h13, 32'hFFFFFF5A, 1, 32'h0);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 32'h5A34AABB);
    issue(1, 2'd2, 0, 32'h14, 32'hDEADBEEF, 1, 32'h0);
    issue(0, 2'd2, 1, 32'h14, 32'h0, 1, 32'hDEADBEEF);
    issue(0, 2'd2, 0, 32'h13, 32'h0, 1, 32'h0);
    issue(1, 2'd1, 0, 32'h11, 32'h12345678, 1, 32'h0);
    issue(0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0);

    // Reset during the read of a byte store: no write, no response.
    w = 0;
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
    check("pre_abort_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_in_rd", 32'(mem_read), 32'd1);
    rst = 1'b1;
    m_loads = 0; m_stores = 0; m_errs = 0;
    @(negedge clk);
    check("abort_no_write", 32'(mem_write), 32'd0);
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(bus.req_ready), 32'd1);
    check("abort_no_write2", 32'(mem_write), 32'd0);
    check("abort_word_kept", bank[4], 32'h5A34AABB);

    // Randomized traffic over the whole bank.
    for (int i = 0; i < 300; i++) begin
      a  = 32'($urandom_range(0, 1023));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, 0, 32'h0);
    end

    w = 0;
    while (sb_q.size() != 0 && w < 100) begin @(negedge clk); w++; end
    check("drain", 32'(sb_q.size()), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 256; i++)
      check($sformatf("bank_word_%0d", i), bank[i],
            {ref_bytes[4 * i + 3], ref_bytes[4 * i + 2], ref_bytes[4 * i + 1], ref_bytes[4 * i]});

`ifdef LSU_STATS_EN
    check("stat_loads", stat_loads, 32'(m_loads));
    check("stat_stores", stat_stores, 32'(m_stores));
    check("stat_errs", stat_errs, 32'(m_errs));
`else
    check("stat_loads_off", stat_loads, 32'd0);
    check("stat_stores_off", stat_stores, 32'd0);
    check("stat_errs_off", stat_errs, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath's memory stage and the 256x32 word-addressed data memory bank.
- Accepts one load/store request at a time and performs byte, halfword and word accesses.
- Byte and halfword stores are done as read-modify-write, since the bank only does whole-word writes.
- Loads are sign- or zero-extended; misaligned accesses are flagged and never reach memory.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error)
- req_unsigned  in  1  loads: zero-extend when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  extended load data (0 for stores and errors)
- rsp_err  out  1  misaligned or reserved size
- mem_read  out  1  to bank memread
- mem_write  out  1  to bank memwrite
- mem_addr  out  ADDR_W  byte address, low 2 bits forced 00
- mem_wdata  out  DATA_W  full word to bank
- mem_rdata  in  DATA_W  bank readdata, combinational, valid in the same cycle as mem_read

Behaviour:
- Reset values: all outputs 0, except req_ready=1 once in IDLE after reset; state=IDLE.
- Request capture: a request is accepted on the clk edge where req_valid && req_ready. The unit registers op, size, unsigned, addr and wdata.
- FSM states: IDLE, RD, WR, RESP.
- IDLE, on accept:
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with err.
  - Load -> RD.
  - SW -> WR.
  - SB/SH -> RD.
- RD:
  - mem_read=1 and mem_addr={addr[31:2],2'b00} for exactly one cycle; mem_rdata captured at the edge.
  - Load -> RESP.
  - SB/SH -> WR.
- WR:
  - mem_write=1 for one cycle.
  - SW: mem_wdata=wdata.
  - SB: captured word with lane addr[1:0] replaced by wdata[7:0].
  - SH: captured word with lane addr[1] (bits 15:0 or 31:16) replaced by wdata[15:0].
  - Next state -> RESP.
- RESP:
  - rsp_valid=1 for one cycle; rsp_err as decided at accept.
  - Next state -> IDLE.
- Byte-lane selection and extension:
  - Little-endian; lane k = bits 8k+7:8k.
  - LB/LH sign-extend unless req_unsigned. LW ignores req_unsigned.
- Latency, accept edge to rsp_valid high:
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- mem_read and mem_write are never both high. Both are low in IDLE and RESP. mem_wdata is 0 outside WR.
- No response back-pressure: rsp_valid is a pulse and the consumer must take it.
- req_valid while busy is ignored (req_ready=0); the requester holds it.
- Reset mid-operation: the next edge returns to IDLE with all outputs cleared.
  - Reset asserted in RD aborts the pending SB/SH; no write is issued.
  - Reset in WR: the write issued in that cycle (combinational bank) may land; no response is produced.

Optional Feature:
- LSU_STATS_EN defined: three 32-bit wrapping counters, stat_loads, stat_stores and stat_errs.
  - Each increments in RESP according to the response type.
  - Cleared by rst; exposed as output ports.
- Undefined: the counters are not instantiated and the ports are driven 0.

Decomposition:
- Shared package lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, DATA_W/ADDR_W constants.
- Natural sub-module: lsu_lane_align, purely combinational.
  - Load direction: lane extract plus sign/zero extend.
  - Store direction: lane merge for RMW.
- The FSM stays in load_store_unit.

Test Plan:
- Preload word 0x10=0x8899AABB; LB addr 0x11 -> rsp_rdata=0xFFFFFFAA at accept+2, one mem_read pulse with mem_addr=0x10.
- Same word, LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB.
- SH addr 0x12 wdata 0x00001234 -> RD then WR with mem_wdata=0x1234AABB, rsp at accept+3; a following LW 0x10 returns 0x1234AABB.
- SB addr 0x13 wdata 0xFFFFFF5A -> mem_wdata=0x5AxxAABB (lane 3 only changed); SW 0x14 wdata 0xDEADBEEF -> single write, rsp at accept+2.
- LW 0x13, SH 0x11, size=11 -> rsp_err=1, rsp_rdata=0 at accept+1, mem_read/mem_write never asserted.
- SB to 0x10 with rst asserted during RD -> no mem_write, no rsp_valid, memory word unchanged, req_ready=1 the cycle after reset releases.
